// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: bus widths, response codes, read-master states.
package axi4lite_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PROT_W = 3;
  localparam int unsigned RESP_W = 2;
  localparam int unsigned CNT_W  = 16;

  localparam logic [RESP_W-1:0] OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RESP,
    DRAIN
  } rd_state_e;

  // Captured AR payload.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PROT_W-1:0] prot;
  } ar_req_t;

  // Registered user response payload.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
    logic              timeout;
  } rd_rsp_t;

endpackage

// File: rtl/axi4lite_read_master.sv
// Single-outstanding AXI4-Lite read master with an R-channel timeout.
// A timed-out transaction answers SLVERR and then drains the late R beat.
module axi4lite_read_master
  import axi4lite_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [PROT_W-1:0] req_prot,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [PROT_W-1:0] arprot,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [RESP_W-1:0] rresp,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [RESP_W-1:0] rsp_resp,
  output logic              rsp_timeout,
  output logic              busy
);

  // The timeout fires in the DATA cycle whose edge would bring the count to
  // TIMEOUT_CYCLES, so the response appears TIMEOUT_CYCLES cycles after DATA entry.
  localparam logic             TIMEOUT_EN   = (TIMEOUT_CYCLES != '0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  rd_state_e        state_q, state_d;
  ar_req_t          ar_q, ar_d;
  rd_rsp_t          rsp_q, rsp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain_q, drain_d;
  logic             req_ready_q, req_ready_d;
  logic             arvalid_q, arvalid_d;
  logic             rready_q, rready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic             timeout_hit;

  assign timeout_hit = TIMEOUT_EN && (cnt_q == TIMEOUT_LAST);

  // State and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      ar_q        <= '0;
      rsp_q       <= '{data: '0, resp: OKAY, timeout: 1'b0};
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      req_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ar_q        <= ar_d;
      rsp_q       <= rsp_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      req_ready_q <= req_ready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, payload capture and next values of the registered handshakes.
  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          ar_d.addr = req_addr;
          ar_d.prot = req_prot;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (arvalid_q && arready) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (rvalid) begin
          rsp_d.data    = rdata;
          rsp_d.resp    = rresp;
          rsp_d.timeout = 1'b0;
          state_d       = RESP;
        end else if (timeout_hit) begin
          rsp_d.data    = '0;
          rsp_d.resp    = SLVERR;
          rsp_d.timeout = 1'b1;
          drain_d       = 1'b1;
          state_d       = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = drain_q ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (rvalid) begin
          drain_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    arvalid_d   = (state_d == ADDR);
    rready_d    = (state_d == DATA) || (state_d == DRAIN);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  assign req_ready   = req_ready_q;
  assign arvalid     = arvalid_q;
  assign araddr      = ar_q.addr;
  assign arprot      = ar_q.prot;
  assign rready      = rready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_q.data;
  assign rsp_resp    = rsp_q.resp;
  assign rsp_timeout = rsp_q.timeout;
  assign busy        = busy_q;

endmodule

// File: tb/tb_axi4lite_read_master.sv
// Directed bench for the AXI4-Lite read master: vector table plus corner sequences.
module tb_axi4lite_read_master;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_wait;
    int          r_wait;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic        exp_to;
  } vec_t;

  logic        aclk;
  logic        aresetn;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_prot;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rsp_ready;

  logic        req_ready, arvalid, rready, rsp_valid, rsp_timeout, busy;
  logic [31:0] araddr, rsp_data;
  logic [2:0]  arprot;
  logic [1:0]  rsp_resp;

  logic        req_ready_4, arvalid_4, rready_4, rsp_valid_4, rsp_timeout_4, busy_4;
  logic [31:0] araddr_4, rsp_data_4;
  logic [2:0]  arprot_4;
  logic [1:0]  rsp_resp_4;

  int errors = 0;
  int checks = 0;
  vec_t vecs [5];

  axi4lite_read_master #(.TIMEOUT_CYCLES(16'd8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_prot(req_prot),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  axi4lite_read_master #(.TIMEOUT_CYCLES(16'd4)) dut4 (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready_4), .req_addr(req_addr), .req_prot(req_prot),
    .arvalid(arvalid_4), .arready(arready), .araddr(araddr_4), .arprot(arprot_4),
    .rvalid(rvalid), .rready(rready_4), .rdata(rdata), .rresp(rresp),
    .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready), .rsp_data(rsp_data_4),
    .rsp_resp(rsp_resp_4), .rsp_timeout(rsp_timeout_4), .busy(busy_4)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Hard stop in case a sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One full transaction from the vector table, checked cycle by cycle.
  task automatic run_txn(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    check1({t, ".req_ready_idle"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_prot  = v.prot;
    step();
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_prot  = 3'd0;
    check1({t, ".arvalid"}, arvalid, 1'b1);
    check({t, ".araddr"}, araddr, v.addr);
    check({t, ".arprot"}, 32'(arprot), 32'(v.prot));
    check1({t, ".req_ready_addr"}, req_ready, 1'b0);
    check1({t, ".busy"}, busy, 1'b1);
    for (int i = 0; i < v.ar_wait; i++) begin
      step();
      check1({t, ".arvalid_hold"}, arvalid, 1'b1);
      check({t, ".araddr_hold"}, araddr, v.addr);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    check1({t, ".arvalid_drop"}, arvalid, 1'b0);
    check1({t, ".rready"}, rready, 1'b1);
    for (int i = 0; i < v.r_wait; i++) begin
      step();
      check1({t, ".rsp_valid_wait"}, rsp_valid, 1'b0);
    end
    rvalid = 1'b1;
    rdata  = v.rdata;
    rresp  = v.rresp;
    step();
    rvalid = 1'b0;
    rdata  = 32'hBAD0_BAD0;
    rresp  = 2'b11;
    check1({t, ".rsp_valid"}, rsp_valid, 1'b1);
    check1({t, ".rready_off"}, rready, 1'b0);
    check({t, ".rsp_data"}, rsp_data, v.exp_data);
    check({t, ".rsp_resp"}, 32'(rsp_resp), 32'(v.exp_resp));
    check1({t, ".rsp_timeout"}, rsp_timeout, v.exp_to);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check1({t, ".rsp_valid_done"}, rsp_valid, 1'b0);
    check1({t, ".req_ready_done"}, req_ready, 1'b1);
    check1({t, ".busy_done"}, busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0010, 3'd0, 32'hDEAD_BEEF, 2'b00, 0, 2, 32'hDEAD_BEEF, 2'b00, 1'b0};
    vecs[1] = '{32'h0000_0013, 3'd2, 32'h1234_5678, 2'b10, 1, 0, 32'h1234_5678, 2'b10, 1'b0};
    vecs[2] = '{32'hFFFF_FFFC, 3'd7, 32'hA5A5_5A5A, 2'b00, 3, 6, 32'hA5A5_5A5A, 2'b00, 1'b0};
    vecs[3] = '{32'h8000_0000, 3'd5, 32'h0000_0000, 2'b10, 0, 0, 32'h0000_0000, 2'b10, 1'b0};
    // rvalid lands in the timeout cycle (count 7 with limit 8): data must win.
    vecs[4] = '{32'h0000_0100, 3'd1, 32'h5555_AAAA, 2'b00, 2, 7, 32'h5555_AAAA, 2'b00, 1'b0};

    aresetn   = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_prot  = 3'd0;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rdata     = 32'hBAD0_BAD0;
    rresp     = 2'b11;
    rsp_ready = 1'b0;

    // Reset values.
    #1 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check1("rst.req_ready", req_ready, 1'b0);
    check1("rst.arvalid", arvalid, 1'b0);
    check("rst.araddr", araddr, 32'h0);
    check1("rst.rready", rready, 1'b0);
    check1("rst.rsp_valid", rsp_valid, 1'b0);
    check("rst.rsp_data", rsp_data, 32'h0);
    check1("rst.busy", busy, 1'b0);
    aresetn = 1'b1;
    step();
    check1("rst.req_ready_after", req_ready, 1'b1);
    check1("rst.req_ready_after4", req_ready_4, 1'b1);

    // AR backpressure never times out (limit 4, arready low for 6 cycles).
    req_valid = 1'b1;
    req_addr  = 32'h0000_0044;
    req_prot  = 3'd1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check1("arhold.arvalid", arvalid_4, 1'b1);
      check("arhold.araddr", araddr_4, 32'h0000_0044);
      check1("arhold.rsp_valid", rsp_valid_4, 1'b0);
      check1("arhold.rsp_timeout", rsp_timeout_4, 1'b0);
      check1("arhold.rready", rready_4, 1'b0);
      step();
    end
    check1("arhold.arvalid_end", arvalid_4, 1'b1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    check1("arhold.rready_data", rready_4, 1'b1);
    rvalid = 1'b1;
    rdata  = 32'h0BAD_F00D;
    rresp  = 2'b00;
    step();
    rvalid = 1'b0;
    check1("arhold.rsp_valid_end", rsp_valid_4, 1'b1);
    check("arhold.rsp_data", rsp_data_4, 32'h0BAD_F00D);
    check1("arhold.rsp_timeout_end", rsp_timeout_4, 1'b0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check1("arhold.idle", req_ready_4, 1'b1);

    // Vector table.
    for (int k = 0; k < 5; k++) begin
      run_txn(vecs[k], k);
    end

    // R timeout with limit 8, then drain of the late beat.
    req_valid = 1'b1;
    req_addr  = 32'h0000_0020;
    req_prot  = 3'd0;
    step();
    req_valid = 1'b0;
    arready   = 1'b1;
    step();
    arready   = 1'b0;
    check1("to.rready", rready, 1'b1);
    for (int i = 1; i < 8; i++) begin
      step();
      check1("to.rsp_valid_wait", rsp_valid, 1'b0);
    end
    step();
    check1("to.rsp_valid", rsp_valid, 1'b1);
    check("to.rsp_data", rsp_data, 32'h0);
    check("to.rsp_resp", 32'(rsp_resp), 32'h2);
    check1("to.rsp_timeout", rsp_timeout, 1'b1);
    check1("to.rready_off", rready, 1'b0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check1("drain.rsp_valid", rsp_valid, 1'b0);
    check1("drain.rready", rready, 1'b1);
    check1("drain.busy", busy, 1'b1);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0060;
    for (int i = 0; i < 3; i++) begin
      check1("drain.req_ready", req_ready, 1'b0);
      step();
      check1("drain.arvalid", arvalid, 1'b0);
    end
    req_valid = 1'b0;
    rvalid    = 1'b1;
    rdata     = 32'h1111_1111;
    rresp     = 2'b00;
    step();
    rvalid    = 1'b0;
    check1("drain.req_ready_end", req_ready, 1'b1);
    check1("drain.busy_end", busy, 1'b0);
    check1("drain.rsp_valid_end", rsp_valid, 1'b0);
    check1("drain.rready_end", rready, 1'b0);
    run_txn(vecs[1], 5);

    // Response backpressure: rsp_* stable, no new AR.
    req_valid = 1'b1;
    req_addr  = 32'h0000_0030;
    req_prot  = 3'd4;
    step();
    req_valid = 1'b0;
    arready   = 1'b1;
    step();
    arready   = 1'b0;
    rvalid    = 1'b1;
    rdata     = 32'hCAFE_F00D;
    rresp     = 2'b00;
    step();
    rvalid    = 1'b0;
    rdata     = 32'hBAD0_BAD0;
    check1("bp.rsp_valid", rsp_valid, 1'b1);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0070;
    for (int i = 0; i < 3; i++) begin
      step();
      check1("bp.rsp_valid_hold", rsp_valid, 1'b1);
      check("bp.rsp_data_hold", rsp_data, 32'hCAFE_F00D);
      check("bp.rsp_resp_hold", 32'(rsp_resp), 32'h0);
      check1("bp.rsp_timeout_hold", rsp_timeout, 1'b0);
      check1("bp.arvalid", arvalid, 1'b0);
      check1("bp.req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check1("bp.req_ready_end", req_ready, 1'b1);

    // Reset pulse while in DATA: asynchronous clear, no response afterwards.
    req_valid = 1'b1;
    req_addr  = 32'h0000_0040;
    req_prot  = 3'd6;
    step();
    req_valid = 1'b0;
    arready   = 1'b1;
    step();
    arready   = 1'b0;
    check1("mid.rready_data", rready, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    check1("mid.req_ready", req_ready, 1'b0);
    check1("mid.arvalid", arvalid, 1'b0);
    check("mid.araddr", araddr, 32'h0);
    check("mid.arprot", 32'(arprot), 32'h0);
    check1("mid.rready", rready, 1'b0);
    check1("mid.rsp_valid", rsp_valid, 1'b0);
    check("mid.rsp_data", rsp_data, 32'h0);
    check("mid.rsp_resp", 32'(rsp_resp), 32'h0);
    check1("mid.rsp_timeout", rsp_timeout, 1'b0);
    check1("mid.busy", busy, 1'b0);
    check1("mid.busy4", busy_4, 1'b0);
    step();
    check1("mid.req_ready_held", req_ready, 1'b0);
    aresetn = 1'b1;
    step();
    check1("mid.req_ready_after", req_ready, 1'b1);
    check1("mid.busy_after", busy, 1'b0);
    rvalid = 1'b1;
    rdata  = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      step();
      check1("mid.no_rsp", rsp_valid, 1'b0);
      check1("mid.no_ar", arvalid, 1'b0);
    end
    rvalid = 1'b0;
    run_txn(vecs[0], 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
